// File: rtl/rom_download_router.sv
// Routes the MiSTer ioctl download stream into NUM_REGIONS contiguous ROM regions and
// tracks how full each region is. Define ROM_CHECKSUM_EN to add a 16-bit byte-sum output.
module rom_download_router #(
  parameter int unsigned                    NUM_REGIONS = 4,
  parameter int unsigned                    ADDR_W      = 25,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {25'h6000, 25'h4000, 25'h2000, 25'h0000},
  parameter logic [ADDR_W-1:0]             END_ADDR    = 25'h8000
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic [ADDR_W-1:0]      ioctl_addr,
  input  logic [7:0]             ioctl_data,
  input  logic                   ioctl_wr,
  output logic [NUM_REGIONS-1:0] rom_cs,
  output logic                   rom_wr,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] region_loaded,
  output logic                   load_done,
  output logic                   bad_addr_err
`ifdef ROM_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  function automatic logic [ADDR_W-1:0] base_of(input int i);
    return REGION_BASE[i*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] limit_of(input int i);
    if (i + 1 >= int'(NUM_REGIONS)) return END_ADDR;
    return REGION_BASE[(i+1)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [CNT_W-1:0] size_of(input int i);
    return CNT_W'(limit_of(i)) - CNT_W'(base_of(i));
  endfunction

  state_t                   state_q, state_d;
  logic                     dl_q;
  logic                     rise_c, fall_c;
  logic                     clear_c, load_c, done_c;
  logic [NUM_REGIONS-1:0]   hit_c;
  logic [ADDR_W-1:0]        offset_c;
  logic                     in_range_c, wr_ok_c, bad_c;
  logic [CNT_W-1:0]         cnt_q [NUM_REGIONS];

  // dl_q resets high so a download already in progress at reset release is not a rising edge
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) dl_q <= 1'b1;
    else        dl_q <= ioctl_download;
  end

  assign rise_c = ioctl_download & ~dl_q;
  assign fall_c = ~ioctl_download & dl_q;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise_c) state_d = LOAD;
      LOAD:    if (fall_c) state_d = DONE;
      DONE:    if (rise_c) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clear_c = 1'b0;
    load_c  = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      IDLE:    clear_c = rise_c;
      LOAD:    load_c  = 1'b1;
      DONE: begin
        clear_c = rise_c;
        done_c  = ~rise_c;
      end
      default: ;
    endcase
  end

  // Region decode: at most one region matches since bases ascend
  always_comb begin
    hit_c    = '0;
    offset_c = '0;
    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (ioctl_addr >= base_of(i) && ioctl_addr < limit_of(i)) begin
        hit_c[i] = 1'b1;
        offset_c = ioctl_addr - base_of(i);
      end
    end
  end

  assign in_range_c = |hit_c;
  assign wr_ok_c    = load_c & ioctl_wr & in_range_c;
  assign bad_c      = load_c & ioctl_wr & ~in_range_c;

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      rom_wr       <= 1'b0;
      rom_cs       <= '0;
      rom_addr     <= '0;
      rom_data     <= '0;
      bad_addr_err <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      rom_wr <= wr_ok_c;
      rom_cs <= wr_ok_c ? hit_c : '0;
      if (wr_ok_c) begin
        rom_addr <= offset_c;
        rom_data <= ioctl_data;
      end
      if (clear_c)    bad_addr_err <= 1'b0;
      else if (bad_c) bad_addr_err <= 1'b1;
      load_done <= done_c & (&region_loaded);
    end
  end

  // Per-region write counters, saturating at the region size
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGIONS); i++) cnt_q[i] <= '0;
      region_loaded <= '0;
    end else if (clear_c) begin
      for (int i = 0; i < int'(NUM_REGIONS); i++) cnt_q[i] <= '0;
      region_loaded <= '0;
    end else if (wr_ok_c) begin
      for (int i = 0; i < int'(NUM_REGIONS); i++) begin
        if (hit_c[i] && cnt_q[i] != size_of(i)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          if (cnt_q[i] + CNT_W'(1) == size_of(i)) region_loaded[i] <= 1'b1;
        end
      end
    end
  end

`ifdef ROM_CHECKSUM_EN
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset)       checksum <= '0;
    else if (clear_c) checksum <= '0;
    else if (wr_ok_c) checksum <= checksum + 16'(ioctl_data);
  end
`endif

endmodule

// File: tb/tb_rom_download_router.sv
// Directed bench for rom_download_router: per-cycle expected-output scoreboard plus
// fill/done/error checks at the default 4 x 8 KiB region map.
module tb_rom_download_router;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 25;

  logic          clk_49m = 1'b0;
  logic          reset = 1'b0;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_data = '0;
  logic [NR-1:0] rom_cs, region_loaded;
  logic          rom_wr, load_done, bad_addr_err;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
`ifdef ROM_CHECKSUM_EN
  logic [15:0]   checksum;
  logic [15:0]   m_sum = '0;
`endif

  typedef struct packed {
    logic          wr;
    logic [NR-1:0] cs;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_state = 0;    // 0 idle, 1 load, 2 done
  logic m_prev = 1'b1;

  always #10 clk_49m = ~clk_49m;

  rom_download_router #(
    .NUM_REGIONS(NR),
    .ADDR_W(AW),
    .REGION_BASE({25'h6000, 25'h4000, 25'h2000, 25'h0000}),
    .END_ADDR(25'h8000)
  ) dut (
    .clk_49m(clk_49m),
    .reset(reset),
    .ioctl_download(ioctl_download),
    .ioctl_addr(ioctl_addr),
    .ioctl_data(ioctl_data),
    .ioctl_wr(ioctl_wr),
    .rom_cs(rom_cs),
    .rom_wr(rom_wr),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .region_loaded(region_loaded),
    .load_done(load_done),
    .bad_addr_err(bad_addr_err)
`ifdef ROM_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the routed output, then compare after the edge
  task automatic drive(input logic dl, input logic wr, input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = a;
    ioctl_data     = d;
    e = '0;
    if (m_state == 1 && wr && a < 25'h8000) begin
      e.wr   = 1'b1;
      e.cs   = NR'(1) << a[14:13];
      e.addr = AW'(a[12:0]);
      e.data = d;
`ifdef ROM_CHECKSUM_EN
      m_sum = m_sum + 16'(d);
`endif
    end
    q.push_back(e);
    if (dl && !m_prev && m_state != 1) begin
      m_state = 1;
`ifdef ROM_CHECKSUM_EN
      m_sum = '0;
`endif
    end else if (!dl && m_prev && m_state == 1) begin
      m_state = 2;
    end
    m_prev = dl;
    @(posedge clk_49m);
    #1;
    e = q.pop_front();
    chk("rom_wr", 32'(rom_wr), 32'(e.wr));
    chk("rom_cs", 32'(rom_cs), 32'(e.cs));
    if (e.wr) begin
      chk("rom_addr", 32'(rom_addr), 32'(e.addr));
      chk("rom_data", 32'(rom_data), 32'(e.data));
    end
  endtask

  initial begin
    // Start a download, leave a routed write and an error pending, then reset mid-download
    repeat (2) @(posedge clk_49m);
    @(negedge clk_49m);
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 25'h8000, 8'h33);
    chk("bad_before_rst", 32'(bad_addr_err), 32'd1);
    drive(1'b1, 1'b1, 25'h1234, 8'h5A);
    @(negedge clk_49m);
    reset = 1'b0;
    #1;
    chk("rst_rom_wr", 32'(rom_wr), 32'd0);
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rom_data", 32'(rom_data), 32'd0);
    chk("rst_loaded", 32'(region_loaded), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_bad", 32'(bad_addr_err), 32'd0);
`ifdef ROM_CHECKSUM_EN
    chk("rst_checksum", 32'(checksum), 32'd0);
`endif
    repeat (2) @(posedge clk_49m);
    @(negedge clk_49m);
    reset = 1'b1;
    q.delete();
    m_state = 0;
    m_prev  = 1'b1;
`ifdef ROM_CHECKSUM_EN
    m_sum = '0;
`endif

    // Download still high after reset: ignored until a fresh rising edge
    repeat (3) drive(1'b1, 1'b1, 25'h1234, 8'hA5);
    drive(1'b0, 1'b0, 25'h1234, 8'h00);
    drive(1'b1, 1'b0, 25'h1234, 8'h00);
    drive(1'b1, 1'b1, 25'h1234, 8'h5A);
    drive(1'b0, 1'b0, 25'h1234, 8'h00);
    drive(1'b0, 1'b1, 25'h2000, 8'h11);   // write in DONE is ignored

    // Full download, mostly back-to-back with occasional gaps; last write coincides with the fall
    drive(1'b1, 1'b0, '0, '0);
    for (int a = 0; a < 'h7FFF; a++) begin
      drive(1'b1, 1'b1, AW'(a), 8'(a ^ (a >> 8)));
      if (a % 16 == 5) drive(1'b1, 1'b0, AW'(a), 8'h00);
    end
    chk("full_loaded_pre", 32'(region_loaded), 32'h7);
    chk("full_done_pre", 32'(load_done), 32'd0);
    drive(1'b0, 1'b1, 25'h7FFF, 8'hC3);
    chk("full_loaded", 32'(region_loaded), 32'hF);
    drive(1'b0, 1'b0, 25'h7FFF, 8'h00);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_bad", 32'(bad_addr_err), 32'd0);
`ifdef ROM_CHECKSUM_EN
    chk("full_checksum", 32'(checksum), 32'(m_sum));
`endif

    // Partial download with an out-of-range write
    drive(1'b1, 1'b0, '0, '0);
    chk("restart_done", 32'(load_done), 32'd0);
    chk("restart_loaded", 32'(region_loaded), 32'd0);
    drive(1'b1, 1'b1, 25'h8000, 8'h99);
    chk("oor_bad", 32'(bad_addr_err), 32'd1);
    chk("oor_loaded", 32'(region_loaded), 32'd0);
    for (int a = 0; a < 'h6000; a++) drive(1'b1, 1'b1, AW'(a), 8'(a));
    chk("part_loaded_load", 32'(region_loaded), 32'h7);
    drive(1'b1, 1'b1, 25'h1FFFFFF, 8'h44);
    repeat (3) drive(1'b0, 1'b0, '0, '0);
    chk("part_loaded", 32'(region_loaded), 32'h7);
    chk("part_done", 32'(load_done), 32'd0);
    chk("part_bad_sticky", 32'(bad_addr_err), 32'd1);
    drive(1'b1, 1'b0, '0, '0);
    chk("bad_cleared", 32'(bad_addr_err), 32'd0);
    chk("loaded_cleared", 32'(region_loaded), 32'd0);

    // Byte sum excludes the out-of-range byte
    drive(1'b1, 1'b1, 25'h0010, 8'hFF);
    drive(1'b1, 1'b1, 25'h0011, 8'h01);
    drive(1'b1, 1'b1, 25'h8000, 8'h77);
    drive(1'b1, 1'b1, 25'h0012, 8'h80);
`ifdef ROM_CHECKSUM_EN
    chk("checksum_const", 32'(checksum), 32'h0180);
    chk("checksum_model", 32'(checksum), 32'(m_sum));
`endif
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    chk("small_done", 32'(load_done), 32'd0);
    chk("small_bad", 32'(bad_addr_err), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
